mem_ctrl: RTL
=============

# mem_ctrl

Memory controller: the responder side of the load/store buffer's memory request interface and of the instruction-fetch interface. It arbitrates between LSB and IF requests and serialises each access onto the 8-bit single-port RAM/IO bus, one byte per cycle. It returns a one-cycle completion pulse with assembled, extended load data. It sits between the LSB/IF units and the top-level RAM/IO ports.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state, forces mem_wr=0
- flush  in  1  branch mispredict (jump_wrong); aborts loads/fetches, never stores
- ls_req  in  1  LSB request valid; held with its fields stable until ls_done
- ls_addr  in  32  byte address
- ls_insty  in  3  access type: LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7
- ls_wdata  in  32  store data; low bytes used
- ls_done  out  1  one-cycle completion pulse (load or store)
- ls_rdata  out  32  extended load data, valid with ls_done
- if_req  in  1  fetch request; held with if_addr stable until if_done
- if_addr  in  32  fetch address (word)
- if_done  out  1  one-cycle fetch completion pulse
- if_inst  out  32  fetched instruction, valid with if_done
- mem_din  in  8  RAM/IO read byte; returns data for the previous cycle's mem_a
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full; stalls IO writes

## Operation
- States: IDLE, LS_LOAD, LS_STORE, FETCH, DONE.
- IDLE samples requests only in IDLE; ls_req beats if_req. Accepted fields are latched; byte count n = 1 (B/BU/SB), 2 (H/HU/SH), 4 (W/SW/fetch).
- LS_LOAD/FETCH: issue mem_a=addr+i for i=0..n-1, capture mem_din one cycle later into byte lane i, little-endian.
- LS_STORE: drive mem_a=addr+i, mem_dout=wdata[8i+7:8i], mem_wr=1 for i=0..n-1.
- IO write stall: if addr[17:16]==2'b11 and io_buffer_full=1, hold the current byte with mem_wr=0 and do not advance i.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW raw.
- DONE: pulse ls_done or if_done for exactly one cycle, then IDLE. A request presented during DONE is ignored. It is accepted in the following IDLE cycle.
- Flush in LS_LOAD or FETCH: go to IDLE next cycle, no done pulse, captured bytes discarded.
- Flush in LS_STORE: ignored; the store completes and pulses ls_done.
- Flush in DONE: the pulse still occurs. The LSB consumes a same-cycle finish during flush.
- Flush in IDLE: no request is accepted that cycle.
- Addresses add with 32-bit wrap (0xFFFFFFFF+1 = 0).

## Timing
- Reset values: ls_done=0, if_done=0, ls_rdata=0, if_inst=0, mem_a=0, mem_dout=0, mem_wr=0, state IDLE.
- All outputs are registered.
- Request accepted at edge ending cycle T.
- Load/fetch: mem_a=addr+i during T+1+i; byte i sampled T+2+i; done pulse in cycle T+2+n. LW/fetch: T+6. LB: T+3.
- Store: writes in T+1..T+n; done in T+1+n. SW: T+5. Each io_buffer_full stall cycle adds one.
- Back-to-back throughput: one idle cycle between accesses, from DONE→IDLE.
- rdy=0: every register holds; the mem_wr output is gated to 0 and restored when rdy returns.

## Structure
- Shared defines package: insty encodings, IO-region test (addr[17:16]==2'b11), byte-count and load-extension functions.
- No sub-module; a single FSM with a 3-bit byte counter and a 32-bit assembly register.

## Test plan
- LW to 0x1000 with RAM bytes 78,56,34,12 → ls_done at T+6, ls_rdata=0x12345678; mem_a steps 0x1000..0x1003.
- LB and LBU of byte 0x80 → ls_rdata 0xFFFFFF80 and 0x00000080 respectively; LH of 0x8001 → 0xFFFF8001.
- SH 0xABCD to 0x2002 → mem_wr with (0x2002,CD) then (0x2003,AB); ls_done at T+3. Flush asserted at T+1 does not abort it.
- SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 through the stall; write occurs after; ls_done at T+5.
- ls_req and if_req raised together → the load is served first; the fetch is accepted in the IDLE cycle after ls_done. Flush at fetch cycle T+3 → no if_done, state returns to IDLE.
- rst asserted mid-LW → next cycle all outputs 0 and state IDLE. A following fetch of 0x0 completes normally at T+6.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access encodings, FSM states,
// IO-region decode, byte-count and load-extension helpers.
package mem_ctrl_pkg;
  typedef enum logic [2:0] {LB = 3'd0, LH, LW, LBU, LHU, SB, SH, SW} insty_e;
  typedef enum logic [2:0] {IDLE, LS_LOAD, LS_STORE, FETCH, DONE} state_e;

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic logic is_store(input logic [2:0] ty);
    return (ty == SB) || (ty == SH) || (ty == SW);
  endfunction

  function automatic logic [2:0] byte_cnt(input logic [2:0] ty);
    case (insty_e'(ty))
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] ty, input logic [31:0] w);
    case (insty_e'(ty))
      LB:      return {{24{w[7]}}, w[7:0]};
      LH:      return {{16{w[15]}}, w[15:0]};
      LBU:     return {24'b0, w[7:0]};
      LHU:     return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// LSB / IF request ports plus the byte-wide RAM/IO bus seen by mem_ctrl.
interface mem_ctrl_if;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [2:0]  ls_insty;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output ls_req, ls_addr, ls_insty, ls_wdata, if_req, if_addr, mem_din, io_buffer_full,
    input  ls_done, ls_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );
  modport slave (
    input  ls_req, ls_addr, ls_insty, ls_wdata, if_req, if_addr, mem_din, io_buffer_full,
    output ls_done, ls_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates LSB vs fetch requests and serialises each access onto the 8-bit
// RAM/IO bus, one byte per cycle, returning a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  mem_ctrl_if.slave  bus
);
  state_e      state, state_n;
  logic [2:0]  cnt, cnt_n, nb, nb_n, ty, ty_n, cnt_inc;
  logic [1:0]  lane;
  logic [31:0] addr, addr_n, wdata, wdata_n, asm_q, asm_n, asm_cap;
  logic [31:0] ls_rdata_q, ls_rdata_n, if_inst_q, if_inst_n, mem_a_q, mem_a_n;
  logic [7:0]  dout_q, dout_n;
  logic        ls_done_q, ls_done_n, if_done_q, if_done_n, wr_q, wr_n, stall;

  assign cnt_inc = cnt + 3'd1;
  assign lane    = 2'(cnt - 3'd1);
  assign stall   = is_io(addr) && bus.io_buffer_full;

  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; nb <= '0; ty <= '0; addr <= '0; wdata <= '0; asm_q <= '0;
      ls_done_q <= 1'b0; if_done_q <= 1'b0; ls_rdata_q <= '0; if_inst_q <= '0;
      mem_a_q <= '0; dout_q <= '0; wr_q <= 1'b0;
    end else if (rdy) begin
      cnt <= cnt_n; nb <= nb_n; ty <= ty_n; addr <= addr_n; wdata <= wdata_n; asm_q <= asm_n;
      ls_done_q <= ls_done_n; if_done_q <= if_done_n; ls_rdata_q <= ls_rdata_n;
      if_inst_q <= if_inst_n; mem_a_q <= mem_a_n; dout_q <= dout_n; wr_q <= wr_n;
    end
  end

  always_comb begin
    state_n = state; cnt_n = cnt; nb_n = nb; ty_n = ty; addr_n = addr; wdata_n = wdata;
    asm_n = asm_q; ls_done_n = 1'b0; if_done_n = 1'b0; ls_rdata_n = ls_rdata_q;
    if_inst_n = if_inst_q; mem_a_n = mem_a_q; dout_n = dout_q; wr_n = 1'b0;
    // mem_din carries the byte addressed one cycle earlier, i.e. lane cnt-1
    asm_cap = asm_q;
    for (int k = 0; k < 4; k++)
      if (cnt != 3'd0 && lane == 2'(k)) asm_cap[8*k +: 8] = bus.mem_din;
    case (state)
      IDLE: begin
        if (!flush && bus.ls_req) begin
          ty_n = bus.ls_insty; addr_n = bus.ls_addr; wdata_n = bus.ls_wdata;
          nb_n = byte_cnt(bus.ls_insty); cnt_n = '0; asm_n = '0; mem_a_n = bus.ls_addr;
          if (is_store(bus.ls_insty)) begin
            state_n = LS_STORE;
            dout_n  = bus.ls_wdata[7:0];
            wr_n    = !(is_io(bus.ls_addr) && bus.io_buffer_full);
          end else begin
            state_n = LS_LOAD;
          end
        end else if (!flush && bus.if_req) begin
          state_n = FETCH; addr_n = bus.if_addr; nb_n = 3'd4; cnt_n = '0;
          asm_n = '0; mem_a_n = bus.if_addr;
        end
      end
      LS_LOAD, FETCH: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          asm_n = asm_cap;
          cnt_n = cnt_inc;
          if (cnt_inc < nb) mem_a_n = mem_a_q + 32'd1;
          if (cnt == nb) begin
            state_n = DONE;
            if (state == LS_LOAD) begin
              ls_done_n  = 1'b1;
              ls_rdata_n = load_ext(ty, asm_cap);
            end else begin
              if_done_n = 1'b1;
              if_inst_n = asm_cap;
            end
          end
        end
      end
      LS_STORE: begin
        // a cycle with wr_q low is an IO stall: the byte is retried, not advanced
        if (wr_q) begin
          if (cnt_inc == nb) begin
            state_n   = DONE;
            ls_done_n = 1'b1;
          end else begin
            cnt_n   = cnt_inc;
            mem_a_n = mem_a_q + 32'd1;
            dout_n  = byte_of(wdata, cnt_inc[1:0]);
            wr_n    = !stall;
          end
        end else begin
          wr_n = !stall;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q & rdy;
endmodule
